// File: rtl/ab_source_fifo_if.sv
// ============================================================================
// Module : ab_source_fifo_if
// Brief  : Upstream/downstream bundle for ab_source_fifo; the level signal and
//          the DEPTH parameter exist only when AB_SRC_LEVEL_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ab_source_fifo_if
`ifdef AB_SRC_LEVEL_EN
  #(parameter int DEPTH = 4)
`endif
  ();
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       adv;
  logic       a;
  logic       b;
  logic       out_valid;
  logic       underflow;
`ifdef AB_SRC_LEVEL_EN
  logic [$clog2(DEPTH):0] level;

  modport master (output in_valid, in_data, adv,
                  input  in_ready, a, b, out_valid, underflow, level);
  modport slave  (input  in_valid, in_data, adv,
                  output in_ready, a, b, out_valid, underflow, level);
`else
  modport master (output in_valid, in_data, adv,
                  input  in_ready, a, b, out_valid, underflow);
  modport slave  (input  in_valid, in_data, adv,
                  output in_ready, a, b, out_valid, underflow);
`endif
endinterface

`default_nettype wire

// File: rtl/ab_source_fifo.sv
// ============================================================================
// Module : ab_source_fifo
// Brief  : Circular 2-bit symbol FIFO feeding registered a/b outputs on adv.
//          Optional occupancy port enabled by macro AB_SRC_LEVEL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ab_source_fifo #(
  parameter int DEPTH = 4,
  parameter int VAR   = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  ab_source_fifo_if.slave bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [1:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_a;
  logic            r_b;
  logic            r_out_valid;
  logic            r_underflow;

  logic w_ready;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_ready = (r_count != c_CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = bus.adv && !w_empty;

  // Storage carries no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_out_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      r_out_valid <= w_pop;
      if (w_pop) begin
        {r_a, r_b} <= r_mem[r_rd_ptr];
      end else if (VAR != 0) begin
        {r_a, r_b} <= 2'b00;
      end
      if (bus.adv && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.out_valid = r_out_valid;
  assign bus.underflow = r_underflow;

`ifdef AB_SRC_LEVEL_EN
  assign bus.level = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ab_source_fifo.sv
// ============================================================================
// Module : tb_ab_source_fifo
// Brief  : Self-checking bench; drives VAR=0 and VAR=1 instances in lockstep
//          against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ab_source_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [1:0] s_data = 2'b00;
  logic       s_adv = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef AB_SRC_LEVEL_EN
  ab_source_fifo_if #(.DEPTH(DEPTH)) bus0 ();
  ab_source_fifo_if #(.DEPTH(DEPTH)) bus1 ();
`else
  ab_source_fifo_if bus0 ();
  ab_source_fifo_if bus1 ();
`endif

  assign bus0.in_valid = s_valid;
  assign bus0.in_data  = s_data;
  assign bus0.adv      = s_adv;
  assign bus1.in_valid = s_valid;
  assign bus1.in_data  = s_data;
  assign bus1.adv      = s_adv;

  ab_source_fifo #(.DEPTH(DEPTH), .VAR(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  ab_source_fifo #(.DEPTH(DEPTH), .VAR(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Reference model: a queue of pending symbols plus expected output state.
  logic [1:0] q[$];
  logic [1:0] m_ab0;
  logic [1:0] m_ab1;
  logic       m_ov;
  logic       m_uf;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void compare_all(string tag);
    chk({tag, "_ov0"}, bus0.out_valid, m_ov);
    chk({tag, "_ov1"}, bus1.out_valid, m_ov);
    chk({tag, "_ab0"}, {bus0.a, bus0.b}, m_ab0);
    chk({tag, "_ab1"}, {bus1.a, bus1.b}, m_ab1);
    chk({tag, "_uf0"}, bus0.underflow, m_uf);
    chk({tag, "_uf1"}, bus1.underflow, m_uf);
    chk({tag, "_rdy0"}, bus0.in_ready, q.size() != DEPTH);
    chk({tag, "_rdy1"}, bus1.in_ready, q.size() != DEPTH);
`ifdef AB_SRC_LEVEL_EN
    chk({tag, "_lvl0"}, bus0.level, q.size());
`endif
  endfunction

  // Called between edges: drive, predict, take one edge, compare.
  task automatic step(input logic v, input logic [1:0] d, input logic ad);
    logic       push;
    logic       pop;
    logic [1:0] val;
    s_valid = v;
    s_data  = d;
    s_adv   = ad;
    #1;
    chk("rdy_pre", bus0.in_ready, q.size() != DEPTH);
    push = v && (q.size() != DEPTH);
    pop  = ad && (q.size() != 0);
    if (ad && q.size() == 0) m_uf = 1'b1;
    m_ov = pop;
    if (pop) begin
      val   = q.pop_front();
      m_ab0 = val;
      m_ab1 = val;
    end else begin
      m_ab1 = 2'b00;
    end
    if (push) q.push_back(d);
    @(posedge clk);
    #1;
    compare_all("step");
  endtask

  // Asserts rst between edges, checks the cleared state before any edge,
  // releases on a falling edge and applies (v,d) on the first rising edge.
  task automatic do_reset(input logic v, input logic [1:0] d);
    s_valid = v;
    s_data  = d;
    s_adv   = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    m_ab0 = 2'b00;
    m_ab1 = 2'b00;
    m_ov  = 1'b0;
    m_uf  = 1'b0;
    compare_all("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(v, d, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       adv;
    logic       ov;
    logic [1:0] ab0;
    logic [1:0] ab1;
    logic       uf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int pv;
    int pa;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1};
    tbl[8]  = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1};

    #2;
    do_reset(1'b0, 2'b00);

    // Directed table: ordered pops, VAR idle behaviour, underflow, no bypass.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].adv);
      chk($sformatf("tbl%0d_ov", i), bus0.out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_ab0", i), {bus0.a, bus0.b}, tbl[i].ab0);
      chk($sformatf("tbl%0d_ab1", i), {bus1.a, bus1.b}, tbl[i].ab1);
      chk($sformatf("tbl%0d_uf", i), bus1.underflow, tbl[i].uf);
    end

    // Fill to full with adv low, then one pop reopens in_ready.
    do_reset(1'b0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] iv;
      iv = i;
      step(1'b1, iv[1:0], 1'b0);
      chk($sformatf("fill%0d_rdy", i), bus0.in_ready, (i < 3) ? 1 : 0);
`ifdef AB_SRC_LEVEL_EN
      chk($sformatf("fill%0d_lvl", i), bus0.level, (i < 3) ? i + 1 : 4);
`endif
    end
    step(1'b0, 2'b00, 1'b1);
    chk("full_pop_rdy", bus0.in_ready, 1);
    chk("full_pop_ab", {bus0.a, bus0.b}, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1);
    chk("full_last_ab", {bus0.a, bus0.b}, 2'b11);

    // Steady occupancy of two with simultaneous push and pop.
    do_reset(1'b0, 2'b00);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 1'b1);
      chk($sformatf("steady%0d_ov", i), bus0.out_valid, 1);
`ifdef AB_SRC_LEVEL_EN
      chk($sformatf("steady%0d_lvl", i), bus0.level, 2);
`endif
    end
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);

    // Mid-stream asynchronous reset discards buffered symbols.
    do_reset(1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b1);
    chk("pre_rst_ov", bus0.out_valid, 1);
    chk("pre_rst_uf", bus0.underflow, 1);
    do_reset(1'b1, 2'b01);
    step(1'b0, 2'b00, 1'b1);
    chk("post_rst_ab", {bus0.a, bus0.b}, 2'b01);
    step(1'b0, 2'b00, 1'b1);
    chk("post_rst_uf", bus0.underflow, 1);
    chk("post_rst_ov", bus0.out_valid, 0);

    // Randomised traffic with varying push/pop pressure.
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       begin pv = 80; pa = 30; end
        1:       begin pv = 30; pa = 80; end
        2:       begin pv = 60; pa = 60; end
        default: begin pv = 95; pa = 95; end
      endcase
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < pv, 2'($urandom_range(0, 3)),
             $urandom_range(0, 99) < pa);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ab_source_fifo.md
AB_SOURCE_FIFO -- requirements
Module: ab_source_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 Parameter VAR, default 0, idle-output mode; 0 = hold last a/b, 1 = drive a/b low when no pop occurred.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream symbol valid.
REQ-006 in_ready  output  1  FIFO can accept a symbol.
REQ-007 in_data  input  2  symbol; bit 1 maps to a, bit 0 maps to b.
REQ-008 adv  input  1  downstream request to present the next symbol.
REQ-009 a  output  1  registered symbol bit 1, feeds downstream a.
REQ-010 b  output  1  registered symbol bit 0, feeds downstream b.
REQ-011 out_valid  output  1  one-cycle strobe: a/b were refreshed from the FIFO this cycle.
REQ-012 underflow  output  1  sticky flag: adv was seen while the FIFO was empty.
REQ-013 level  output  $clog2(DEPTH)+1  occupancy count; present only under AB_SRC_LEVEL_EN.

Function
REQ-014 The FIFO SHALL be circular, with wr_ptr, rd_ptr and a count register.
- Pointers wrap from DEPTH-1 to 0.
- Count ranges 0..DEPTH.
REQ-015 in_ready SHALL equal (count != DEPTH) combinationally; it does not depend on adv.
REQ-016 A push SHALL occur when in_valid && in_ready.
- in_data is written at wr_ptr.
- wr_ptr increments.
REQ-017 A pop SHALL occur when adv && (count != 0).
- The head entry is registered into a/b, visible the next cycle.
- rd_ptr increments.
- out_valid = 1 in that next cycle.
REQ-018 Pop latency SHALL be exactly one cycle from adv-high edge to a/b/out_valid update.
REQ-019 out_valid SHALL be 0 in any cycle not following a pop.
REQ-020 With VAR=0, a and b SHALL hold their last popped values when no pop occurs.
REQ-021 With VAR=1, a and b SHALL be 0 in any cycle not following a pop.
REQ-022 Simultaneous push and pop with count in 1..DEPTH-1: count SHALL be unchanged, and both operations take effect.
REQ-023 Full (count=DEPTH): in_ready SHALL be 0, so no push occurs even if a pop occurs that cycle.
REQ-024 Empty (count=0): push with adv SHALL perform only the push.
- There is no bypass.
- a/b follow REQ-020/REQ-021.
- underflow is set.
REQ-025 underflow SHALL be set on adv with count=0 and stay 1 until reset.
REQ-026 Symbols SHALL emerge in strict arrival order, with no loss or duplication.

Reset
REQ-027 rst high SHALL immediately force the following, independent of clk:
- wr_ptr = 0, rd_ptr = 0, count = 0.
- a = 0, b = 0, out_valid = 0, underflow = 0.
- level = 0.
REQ-028 FIFO storage contents SHALL need no reset.
REQ-029 Reset asserted mid-stream SHALL discard all buffered symbols.
- in_ready SHALL read 1 during reset and after release.
REQ-030 The first push SHALL be accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-031 Macro AB_SRC_LEVEL_EN defined: the level port SHALL exist and equal count, registered, same cycle as count.
REQ-032 Macro AB_SRC_LEVEL_EN undefined: the level port and its logic SHALL be absent.
- All other behaviour is identical.

Verification
REQ-033 Push 2'b10, 2'b01, 2'b11, then adv for 3 cycles -> a/b = 1/0, 0/1, 1/1 on consecutive cycles, with out_valid=1 each cycle.
REQ-034 DEPTH=4, hold in_valid=1 for 6 cycles with adv=0 -> in_ready drops to 0 after 4 pushes, and level=4.
- Then adv once -> in_ready=1 the next cycle.
REQ-035 Hold count=2 with push and pop in the same cycle for 5 cycles -> count stays 2, and output order is preserved.
REQ-036 adv with empty FIFO -> out_valid=0 and underflow=1 the next cycle.
- underflow stays 1 after later successful pops.
REQ-037 VAR=1: pop 2'b11, then idle 1 cycle -> a/b = 1/1, then 0/0.
- With VAR=0 the same stimulus -> a/b = 1/1, then 1/1.
REQ-038 Load 3 symbols, then assert rst asynchronously between edges -> count, a, b, out_valid and underflow are 0 before the next edge.
- Afterwards, only newly pushed symbols appear.
